// File: rtl/hilo_unit.sv
// Architectural HI/LO register owner: holds MULT/DIV results pending for a fixed
// latency, serves MTHI/MTLO writes and MFHI/MFLO reads, and stalls conflicting ops.
module hilo_unit #(
    parameter int unsigned MULT_LAT = 4,
    parameter int unsigned DIV_LAT  = 12,
    parameter int unsigned CNT_W    = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic [2:0]  op,
    input  logic [31:0] alu_hi,
    input  logic [31:0] alu_lo,
    input  logic        div_zero,
    input  logic [31:0] rs_data,
    output logic [31:0] read_data,
    output logic        stall,
    output logic        busy,
    output logic [31:0] hi_q,
    output logic [31:0] lo_q
);

    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_MULT = 3'd1;
    localparam logic [2:0] OP_DIV  = 3'd2;
    localparam logic [2:0] OP_MTHI = 3'd3;
    localparam logic [2:0] OP_MTLO = 3'd4;
    localparam logic [2:0] OP_MFHI = 3'd5;
    localparam logic [2:0] OP_MFLO = 3'd6;

    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t            state_q;
    logic              busy_q;
    logic [CNT_W-1:0]  count_q;
    logic [31:0]       pend_hi_q;
    logic [31:0]       pend_lo_q;
    logic              pend_valid_q;
    logic              hilo_op_s;
    logic              accept_s;

    assign busy = busy_q;

    // Stall decode and MFHI/MFLO read mux
    always_comb begin
        hilo_op_s = 1'b0;
        read_data = 32'd0;
        case (op)
            OP_MULT, OP_DIV, OP_MTHI, OP_MTLO, OP_MFHI, OP_MFLO: hilo_op_s = 1'b1;
            default:                                            hilo_op_s = 1'b0;
        endcase
        stall    = busy_q && hilo_op_s;
        accept_s = clk_enable && !stall;
        if (!stall && op == OP_MFHI) begin
            read_data = hi_q;
        end else if (!stall && op == OP_MFLO) begin
            read_data = lo_q;
        end else begin
            read_data = 32'd0;
        end
    end

    // HI/LO state machine: issue, countdown, commit
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            count_q      <= '0;
            pend_hi_q    <= 32'd0;
            pend_lo_q    <= 32'd0;
            pend_valid_q <= 1'b0;
            hi_q         <= 32'd0;
            lo_q         <= 32'd0;
        end else if (clk_enable) begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_s && (op == OP_MULT || op == OP_DIV)) begin
                        pend_hi_q    <= alu_hi;
                        pend_lo_q    <= alu_lo;
                        pend_valid_q <= !(op == OP_DIV && div_zero);
                        count_q      <= (op == OP_MULT) ? MULT_CNT : DIV_CNT;
                        state_q      <= ST_BUSY;
                        busy_q       <= 1'b1;
                    end else if (accept_s && op == OP_MTHI) begin
                        hi_q <= rs_data;
                    end else if (accept_s && op == OP_MTLO) begin
                        lo_q <= rs_data;
                    end
                end
                ST_BUSY: begin
                    // Countdown reaches zero after LAT-1 edges; the next edge commits
                    if (count_q != '0) begin
                        count_q <= count_q - {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        if (pend_valid_q) begin
                            hi_q <= pend_hi_q;
                            lo_q <= pend_lo_q;
                        end
                        pend_valid_q <= 1'b0;
                        state_q      <= ST_IDLE;
                        busy_q       <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_unit.sv
// Scoreboard bench for hilo_unit: expected HI/LO pairs are queued at issue and
// popped when the unit drops stall/busy.
module tb_hilo_unit;

    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_MULT = 3'd1;
    localparam logic [2:0] OP_DIV  = 3'd2;
    localparam logic [2:0] OP_MTHI = 3'd3;
    localparam logic [2:0] OP_MTLO = 3'd4;
    localparam logic [2:0] OP_MFHI = 3'd5;
    localparam logic [2:0] OP_MFLO = 3'd6;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_enable;
    logic [2:0]  op;
    logic [31:0] alu_hi;
    logic [31:0] alu_lo;
    logic        div_zero;
    logic [31:0] rs_data;
    logic [31:0] read_data;
    logic        stall;
    logic        busy;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [63:0] sb_q[$];
    logic [63:0] exp_v;

    always #5 clk = ~clk;

    hilo_unit #(.MULT_LAT(4), .DIV_LAT(12), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .clk_enable(clk_enable), .op(op),
        .alu_hi(alu_hi), .alu_lo(alu_lo), .div_zero(div_zero), .rs_data(rs_data),
        .read_data(read_data), .stall(stall), .busy(busy), .hi_q(hi_q), .lo_q(lo_q)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; clk_enable = 1'b1; op = OP_NONE; div_zero = 1'b0;
        alu_hi = 32'd0; alu_lo = 32'd0; rs_data = 32'd0;
        tick; tick;
        reset = 1'b0; op = OP_MULT;
        #1;
        vec_cnt++; if (hi_q !== 32'd0) begin err_cnt++; $display("FAIL reset_hi: got %h want 0", hi_q); end
        vec_cnt++; if (lo_q !== 32'd0) begin err_cnt++; $display("FAIL reset_lo: got %h want 0", lo_q); end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %b want 0", busy); end
        vec_cnt++; if (stall !== 1'b0) begin err_cnt++; $display("FAIL reset_stall: got %b want 0", stall); end
        op = OP_NONE;
    endtask

    task automatic test_mthi;
        op = OP_MTHI; rs_data = 32'hDEAD_BEEF;
        sb_q.push_back({32'hDEAD_BEEF, 32'd0});
        tick;
        op = OP_MFHI;
        #1;
        exp_v = sb_q.pop_front();
        vec_cnt++; if (read_data !== exp_v[63:32]) begin err_cnt++; $display("FAIL mfhi_data: got %h want %h", read_data, exp_v[63:32]); end
        vec_cnt++; if (stall !== 1'b0) begin err_cnt++; $display("FAIL mfhi_stall: got %b want 0", stall); end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL mthi_busy: got %b want 0", busy); end
        op = OP_NONE;
    endtask

    task automatic test_mult;
        int st;
        alu_hi = 32'h0000_0001; alu_lo = 32'hFFFF_FFFE; op = OP_MULT;
        sb_q.push_back({32'h0000_0001, 32'hFFFF_FFFE});
        tick;
        op = OP_MFLO; st = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (!stall) break;
            vec_cnt++; if (read_data !== 32'd0) begin err_cnt++; $display("FAIL mult_stalled_read: got %h want 0", read_data); end
            st++;
            tick;
        end
        exp_v = sb_q.pop_front();
        vec_cnt++; if (st !== 4) begin err_cnt++; $display("FAIL mult_stall_cycles: got %0d want 4", st); end
        vec_cnt++; if (read_data !== exp_v[31:0]) begin err_cnt++; $display("FAIL mult_mflo: got %h want %h", read_data, exp_v[31:0]); end
        vec_cnt++; if (hi_q !== exp_v[63:32]) begin err_cnt++; $display("FAIL mult_hi: got %h want %h", hi_q, exp_v[63:32]); end
        op = OP_NONE;
    endtask

    task automatic test_div_zero;
        int b;
        op = OP_MTHI; rs_data = 32'd5; tick;
        op = OP_MTLO; rs_data = 32'd7; tick;
        alu_hi = $urandom; alu_lo = $urandom; div_zero = 1'b1; op = OP_DIV;
        sb_q.push_back({32'd5, 32'd7});
        tick;
        div_zero = 1'b0; op = OP_NONE; b = 0;
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            b++;
            tick;
        end
        exp_v = sb_q.pop_front();
        vec_cnt++; if (b !== 12) begin err_cnt++; $display("FAIL divz_busy_cycles: got %0d want 12", b); end
        vec_cnt++; if (hi_q !== exp_v[63:32]) begin err_cnt++; $display("FAIL divz_hi: got %h want %h", hi_q, exp_v[63:32]); end
        vec_cnt++; if (lo_q !== exp_v[31:0]) begin err_cnt++; $display("FAIL divz_lo: got %h want %h", lo_q, exp_v[31:0]); end
    endtask

    task automatic test_back_to_back;
        int st;
        int b;
        alu_hi = 32'h1111_2222; alu_lo = 32'h3333_4444; op = OP_DIV;
        sb_q.push_back({32'h1111_2222, 32'h3333_4444});
        tick;
        alu_hi = 32'hA5A5_0001; alu_lo = 32'h5A5A_0002; op = OP_MULT;
        sb_q.push_back({32'hA5A5_0001, 32'h5A5A_0002});
        st = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (!stall) break;
            st++;
            tick;
        end
        exp_v = sb_q.pop_front();
        vec_cnt++; if (st !== 12) begin err_cnt++; $display("FAIL b2b_stall_cycles: got %0d want 12", st); end
        vec_cnt++; if (hi_q !== exp_v[63:32]) begin err_cnt++; $display("FAIL b2b_div_hi: got %h want %h", hi_q, exp_v[63:32]); end
        vec_cnt++; if (lo_q !== exp_v[31:0]) begin err_cnt++; $display("FAIL b2b_div_lo: got %h want %h", lo_q, exp_v[31:0]); end
        tick;
        op = OP_NONE; b = 0;
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            b++;
            tick;
        end
        exp_v = sb_q.pop_front();
        vec_cnt++; if (b !== 4) begin err_cnt++; $display("FAIL b2b_mult_busy: got %0d want 4", b); end
        vec_cnt++; if (hi_q !== exp_v[63:32]) begin err_cnt++; $display("FAIL b2b_mult_hi: got %h want %h", hi_q, exp_v[63:32]); end
        vec_cnt++; if (lo_q !== exp_v[31:0]) begin err_cnt++; $display("FAIL b2b_mult_lo: got %h want %h", lo_q, exp_v[31:0]); end
    endtask

    task automatic test_clk_enable;
        int b;
        logic [31:0] prev_hi;
        prev_hi = hi_q;
        alu_hi = 32'hCAFE_0000; alu_lo = 32'h0000_F00D; op = OP_MULT;
        sb_q.push_back({32'hCAFE_0000, 32'h0000_F00D});
        tick;
        op = OP_NONE; b = 0;
        for (int k = 0; k < 40; k++) begin
            if (!busy) break;
            b++;
            clk_enable = !(k >= 1 && k <= 3);
            if (k == 3) begin
                vec_cnt++; if (hi_q !== prev_hi) begin err_cnt++; $display("FAIL en_frozen_hi: got %h want %h", hi_q, prev_hi); end
            end
            tick;
        end
        clk_enable = 1'b1;
        exp_v = sb_q.pop_front();
        vec_cnt++; if (b !== 7) begin err_cnt++; $display("FAIL en_busy_cycles: got %0d want 7", b); end
        vec_cnt++; if (hi_q !== exp_v[63:32]) begin err_cnt++; $display("FAIL en_hi: got %h want %h", hi_q, exp_v[63:32]); end
        vec_cnt++; if (lo_q !== exp_v[31:0]) begin err_cnt++; $display("FAIL en_lo: got %h want %h", lo_q, exp_v[31:0]); end
    endtask

    task automatic test_reset_mid_busy;
        alu_hi = 32'h1234_5678; alu_lo = 32'h9ABC_DEF0; op = OP_MULT;
        tick;
        op = OP_NONE;
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0; op = OP_MFHI;
        #1;
        vec_cnt++; if (hi_q !== 32'd0) begin err_cnt++; $display("FAIL rst_mid_hi: got %h want 0", hi_q); end
        vec_cnt++; if (lo_q !== 32'd0) begin err_cnt++; $display("FAIL rst_mid_lo: got %h want 0", lo_q); end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        vec_cnt++; if (stall !== 1'b0) begin err_cnt++; $display("FAIL rst_mid_stall: got %b want 0", stall); end
        op = OP_NONE;
        repeat (8) tick;
        vec_cnt++; if (hi_q !== 32'd0) begin err_cnt++; $display("FAIL rst_mid_no_commit_hi: got %h want 0", hi_q); end
        vec_cnt++; if (lo_q !== 32'd0) begin err_cnt++; $display("FAIL rst_mid_no_commit_lo: got %h want 0", lo_q); end
    endtask

    initial begin
        test_reset;
        test_mthi;
        test_mult;
        test_div_zero;
        test_back_to_back;
        test_clk_enable;
        test_reset_mid_busy;
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
